// File: rtl/fluid_pkg.sv
// Shared types and constants for the fluid dispenser controller.
package fluid_pkg;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_RESTOCK   = 2'd1;
    localparam logic [1:0] ST_BAD_FLUID = 2'd2;
    localparam logic [1:0] ST_ZERO_VOL  = 2'd3;

    localparam int DISC_STEP_DEF = 5;
    localparam int DISC_MAX_DEF  = 25;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PRICE, S_DONE} state_t;

    // Unit price in Rs per litre; unknown fluids price at zero.
    function automatic int unsigned unit_price(input int unsigned fid);
        case (fid)
            0:       return 10;
            1:       return 20;
            2:       return 50;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fluid_price_calc.sv
// Combinational discount and price arithmetic; all outputs zero unless ok.
module fluid_price_calc
    import fluid_pkg::*;
#(
    parameter int FLUID_W   = 2,
    parameter int VOL_W     = 8,
    parameter int VISIT_W   = 8,
    parameter int PRICE_W   = 16,
    parameter int DISC_STEP = DISC_STEP_DEF,
    parameter int DISC_MAX  = DISC_MAX_DEF
) (
    input  logic [FLUID_W-1:0] fluid,
    input  logic [VOL_W-1:0]   vol,
    input  logic [VISIT_W-1:0] prior_visits,
    input  logic               ok,
    output logic [7:0]         disc,
    output logic [PRICE_W-1:0] orig,
    output logic [PRICE_W-1:0] final_price
);

    logic [31:0]        disc_raw;
    logic [7:0]         disc_c;
    logic [PRICE_W-1:0] orig_c;
    logic [PRICE_W+7:0] prod;

    always_comb begin
        disc_raw    = 32'(prior_visits) * 32'(DISC_STEP);
        disc_c      = (disc_raw > 32'(DISC_MAX)) ? 8'(DISC_MAX) : disc_raw[7:0];
        orig_c      = PRICE_W'(vol) * PRICE_W'(unit_price(int'(fluid)));
        // Widened so orig * disc cannot overflow before the divide by 100.
        prod        = (PRICE_W+8)'(orig_c) * (PRICE_W+8)'(disc_c);
        disc        = ok ? disc_c : '0;
        orig        = ok ? orig_c : '0;
        final_price = ok ? orig_c - PRICE_W'(prod / (PRICE_W+8)'(100)) : '0;
    end

endmodule

// File: rtl/fluid_dispense_ctrl.sv
// Dispenser controller: visit table, per-fluid stock with restock, request FSM, registered pricing response.
module fluid_dispense_ctrl
    import fluid_pkg::*;
#(
    parameter int USER_W     = 4,
    parameter int NUM_FLUIDS = 3,
    parameter int FLUID_W    = 2,
    parameter int VOL_W      = 8,
    parameter int STOCK_W    = 8,
    parameter int STOCK_INIT = 50,
    parameter int LOW_THRESH = 10,
    parameter int VISIT_W    = 8,
    parameter int PRICE_W    = 16,
    parameter int DISC_STEP  = DISC_STEP_DEF,
    parameter int DISC_MAX   = DISC_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [USER_W-1:0]     req_user,
    input  logic [FLUID_W-1:0]    req_fluid,
    input  logic [VOL_W-1:0]      req_vol,
    input  logic                  restock_valid,
    input  logic [FLUID_W-1:0]    restock_fluid,
    input  logic [STOCK_W-1:0]    restock_qty,
    output logic                  resp_valid,
    output logic [USER_W-1:0]     resp_user,
    output logic [VISIT_W-1:0]    resp_visits,
    output logic [1:0]            resp_status,
    output logic [7:0]            resp_disc,
    output logic [PRICE_W-1:0]    resp_orig,
    output logic [PRICE_W-1:0]    resp_final,
    output logic [STOCK_W-1:0]    resp_remaining,
    output logic [NUM_FLUIDS-1:0] low_stock
);

    localparam int NUM_USERS = 2**USER_W;

    state_t                             state, state_nxt;
    logic [USER_W-1:0]                  lat_user;
    logic [FLUID_W-1:0]                 lat_fluid;
    logic [VOL_W-1:0]                   lat_vol;
    logic [1:0]                         chk_status;
    logic [VISIT_W-1:0]                 chk_visits, visits_inc;
    logic [NUM_USERS-1:0][VISIT_W-1:0]  visits;
    logic [NUM_FLUIDS-1:0][STOCK_W-1:0] stock, stock_nxt;
    logic                               fluid_ok, commit;
    logic [7:0]                         disc;
    logic [PRICE_W-1:0]                 orig, final_price;

    assign fluid_ok   = int'(lat_fluid) < NUM_FLUIDS;
    assign commit     = (state == S_PRICE) && (chk_status == ST_OK);
    assign visits_inc = (&chk_visits) ? chk_visits : chk_visits + VISIT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = S_PRICE;
            S_PRICE: state_nxt = S_DONE;
            S_DONE: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_user   <= '0;
            lat_fluid  <= '0;
            lat_vol    <= '0;
            chk_status <= ST_OK;
            chk_visits <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                lat_user  <= req_user;
                lat_fluid <= req_fluid;
                lat_vol   <= req_vol;
            end
            if (state == S_CHECK) begin
                chk_visits <= visits[lat_user];
                if (!fluid_ok)                                     chk_status <= ST_BAD_FLUID;
                else if (lat_vol == '0)                            chk_status <= ST_ZERO_VOL;
                else if (int'(lat_vol) > int'(stock[lat_fluid]))   chk_status <= ST_RESTOCK;
                else                                               chk_status <= ST_OK;
            end
        end
    end

    // Restock and deduction merge into one update so a same-cycle pair loses neither.
    always_comb begin : stock_next_c
        logic [STOCK_W+1:0] sum;
        sum       = '0;
        stock_nxt = stock;
        for (int f = 0; f < NUM_FLUIDS; f++) begin
            sum = (STOCK_W+2)'(stock[f]);
            if (restock_valid && int'(restock_fluid) == f) sum = sum + (STOCK_W+2)'(restock_qty);
            if (commit && int'(lat_fluid) == f)            sum = sum - (STOCK_W+2)'(lat_vol);
            stock_nxt[f] = (sum[STOCK_W+1:STOCK_W] != 2'b00) ? '1 : sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < NUM_FLUIDS; f++) stock[f] <= STOCK_W'(STOCK_INIT);
            low_stock <= '0;
        end else begin
            stock <= stock_nxt;
            for (int f = 0; f < NUM_FLUIDS; f++) low_stock[f] <= int'(stock[f]) < LOW_THRESH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       visits           <= '0;
        else if (commit) visits[lat_user] <= visits_inc;
    end

    fluid_price_calc #(
        .FLUID_W   (FLUID_W),
        .VOL_W     (VOL_W),
        .VISIT_W   (VISIT_W),
        .PRICE_W   (PRICE_W),
        .DISC_STEP (DISC_STEP),
        .DISC_MAX  (DISC_MAX)
    ) u_price (
        .fluid        (lat_fluid),
        .vol          (lat_vol),
        .prior_visits (chk_visits),
        .ok           (chk_status == ST_OK),
        .disc         (disc),
        .orig         (orig),
        .final_price  (final_price)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_user      <= '0;
            resp_visits    <= '0;
            resp_status    <= '0;
            resp_disc      <= '0;
            resp_orig      <= '0;
            resp_final     <= '0;
            resp_remaining <= '0;
        end else if (state == S_PRICE) begin
            resp_user      <= lat_user;
            resp_status    <= chk_status;
            resp_disc      <= disc;
            resp_orig      <= orig;
            resp_final     <= final_price;
            resp_visits    <= commit ? visits_inc : chk_visits;
            resp_remaining <= !fluid_ok ? '0 : (commit ? stock_nxt[lat_fluid] : stock[lat_fluid]);
        end
    end

endmodule

// File: tb/tb_fluid_dispense_ctrl.sv
// Directed vector bench for fluid_dispense_ctrl with hand-computed expectations.
module tb_fluid_dispense_ctrl;
    import fluid_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [3:0]  req_user;
    logic [1:0]  req_fluid;
    logic [7:0]  req_vol;
    logic        restock_valid;
    logic [1:0]  restock_fluid;
    logic [7:0]  restock_qty;
    logic        resp_valid;
    logic [3:0]  resp_user;
    logic [7:0]  resp_visits;
    logic [1:0]  resp_status;
    logic [7:0]  resp_disc;
    logic [15:0] resp_orig, resp_final;
    logic [7:0]  resp_remaining;
    logic [2:0]  low_stock;

    always #5 clk = ~clk;

    fluid_dispense_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_user       (req_user),
        .req_fluid      (req_fluid),
        .req_vol        (req_vol),
        .restock_valid  (restock_valid),
        .restock_fluid  (restock_fluid),
        .restock_qty    (restock_qty),
        .resp_valid     (resp_valid),
        .resp_user      (resp_user),
        .resp_visits    (resp_visits),
        .resp_status    (resp_status),
        .resp_disc      (resp_disc),
        .resp_orig      (resp_orig),
        .resp_final     (resp_final),
        .resp_remaining (resp_remaining),
        .low_stock      (low_stock)
    );

    typedef struct {
        logic [3:0]  user;
        logic [1:0]  fluid;
        logic [7:0]  vol;
        logic [7:0]  rs_qty;
        logic [1:0]  status;
        logic [7:0]  visits;
        logic [7:0]  disc;
        logic [15:0] orig;
        logic [15:0] fin;
        logic [7:0]  rem;
        logic [2:0]  low;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ready"},  32'(req_ready), 1);
        chk({tag, ".rvalid"}, 32'(resp_valid), 0);
        chk({tag, ".status"}, 32'(resp_status), 0);
        chk({tag, ".visits"}, 32'(resp_visits), 0);
        chk({tag, ".final"},  32'(resp_final), 0);
        chk({tag, ".remain"}, 32'(resp_remaining), 0);
        chk({tag, ".low"},    32'(low_stock), 0);
    endtask

    task automatic do_req(input string tag, input vec_t v);
        int n;
        bit seen;
        @(negedge clk);
        if (v.rs_qty != 0) begin
            restock_valid = 1'b1;
            restock_fluid = v.fluid;
            restock_qty   = v.rs_qty;
            @(negedge clk);
            restock_valid = 1'b0;
        end
        chk({tag, ".ready"}, 32'(req_ready), 1);
        req_user  = v.user;
        req_fluid = v.fluid;
        req_vol   = v.vol;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 10) begin
            if (resp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, ".latency"}, 32'(n), 3);
        chk({tag, ".user"},    32'(resp_user), 32'(v.user));
        chk({tag, ".status"},  32'(resp_status), 32'(v.status));
        chk({tag, ".visits"},  32'(resp_visits), 32'(v.visits));
        chk({tag, ".disc"},    32'(resp_disc), 32'(v.disc));
        chk({tag, ".orig"},    32'(resp_orig), 32'(v.orig));
        chk({tag, ".final"},   32'(resp_final), 32'(v.fin));
        chk({tag, ".remain"},  32'(resp_remaining), 32'(v.rem));
        @(negedge clk);
        chk({tag, ".pulse"},   32'(resp_valid), 0);
        chk({tag, ".hold"},    32'(resp_final), 32'(v.fin));
        chk({tag, ".low"},     32'(low_stock), 32'(v.low));
    endtask

    initial begin
        int cnt;
        vec_t v;
        //          user  fl    vol    rs     status        vis   disc   orig     fin      rem    low
        tbl[0]  = '{4'd1, 2'd0, 8'd1,  8'd0,  ST_OK,        8'd1, 8'd0,  16'd10,  16'd10,  8'd49, 3'b000};
        tbl[1]  = '{4'd1, 2'd0, 8'd2,  8'd0,  ST_OK,        8'd2, 8'd5,  16'd20,  16'd19,  8'd47, 3'b000};
        tbl[2]  = '{4'd1, 2'd0, 8'd3,  8'd0,  ST_OK,        8'd3, 8'd10, 16'd30,  16'd27,  8'd44, 3'b000};
        tbl[3]  = '{4'd1, 2'd0, 8'd4,  8'd0,  ST_OK,        8'd4, 8'd15, 16'd40,  16'd34,  8'd40, 3'b000};
        tbl[4]  = '{4'd1, 2'd0, 8'd5,  8'd0,  ST_OK,        8'd5, 8'd20, 16'd50,  16'd40,  8'd35, 3'b000};
        tbl[5]  = '{4'd1, 2'd0, 8'd1,  8'd0,  ST_OK,        8'd6, 8'd25, 16'd10,  16'd8,   8'd34, 3'b000};
        tbl[6]  = '{4'd1, 2'd0, 8'd1,  8'd0,  ST_OK,        8'd7, 8'd25, 16'd10,  16'd8,   8'd33, 3'b000};
        tbl[7]  = '{4'd3, 2'd2, 8'd5,  8'd0,  ST_OK,        8'd1, 8'd0,  16'd250, 16'd250, 8'd45, 3'b000};
        tbl[8]  = '{4'd3, 2'd2, 8'd10, 8'd0,  ST_OK,        8'd2, 8'd5,  16'd500, 16'd475, 8'd35, 3'b000};
        tbl[9]  = '{4'd3, 2'd2, 8'd15, 8'd0,  ST_OK,        8'd3, 8'd10, 16'd750, 16'd675, 8'd20, 3'b000};
        tbl[10] = '{4'd3, 2'd2, 8'd20, 8'd0,  ST_OK,        8'd4, 8'd15, 16'd1000,16'd850, 8'd0,  3'b100};
        tbl[11] = '{4'd3, 2'd2, 8'd20, 8'd0,  ST_RESTOCK,   8'd4, 8'd0,  16'd0,   16'd0,   8'd0,  3'b100};
        tbl[12] = '{4'd3, 2'd2, 8'd20, 8'd30, ST_OK,        8'd5, 8'd20, 16'd1000,16'd800, 8'd10, 3'b000};
        tbl[13] = '{4'd5, 2'd3, 8'd5,  8'd0,  ST_BAD_FLUID, 8'd0, 8'd0,  16'd0,   16'd0,   8'd0,  3'b000};
        tbl[14] = '{4'd5, 2'd1, 8'd0,  8'd0,  ST_ZERO_VOL,  8'd0, 8'd0,  16'd0,   16'd0,   8'd50, 3'b000};
        tbl[15] = '{4'd5, 2'd1, 8'd2,  8'd0,  ST_OK,        8'd1, 8'd0,  16'd40,  16'd40,  8'd48, 3'b000};

        reset = 1'b1;
        req_valid = 1'b0; req_user = '0; req_fluid = '0; req_vol = '0;
        restock_valid = 1'b0; restock_fluid = '0; restock_qty = '0;
        do_reset();
        chk_reset("rst");

        for (int i = 0; i < NV; i++) do_req($sformatf("v%0d", i), tbl[i]);

        // Same-cycle restock and deduction on fluid 0, with req_valid held while busy.
        do_reset();
        v = '{4'd2, 2'd0, 8'd10, 8'd0, ST_OK, 8'd1, 8'd0, 16'd100, 16'd100, 8'd40, 3'b000};
        do_req("s5.pre", v);
        @(negedge clk);
        req_user = 4'd2; req_fluid = 2'd0; req_vol = 8'd3; req_valid = 1'b1;
        @(negedge clk);
        chk("s5.busy_check", 32'(req_ready), 0);
        @(negedge clk);
        chk("s5.busy_price", 32'(req_ready), 0);
        restock_valid = 1'b1; restock_fluid = 2'd0; restock_qty = 8'd5;
        @(negedge clk);
        restock_valid = 1'b0;
        chk("s5.rvalid", 32'(resp_valid), 1);
        chk("s5.busy_done", 32'(req_ready), 0);
        req_valid = 1'b0;
        chk("s5.final", 32'(resp_final), 29);
        chk("s5.visits", 32'(resp_visits), 2);
        chk("s5.remain", 32'(resp_remaining), 42);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("s5.no_second", 32'(cnt), 0);
        v = '{4'd2, 2'd0, 8'd2, 8'd0, ST_OK, 8'd3, 8'd10, 16'd20, 16'd18, 8'd40, 3'b000};
        do_req("s5.post", v);

        // Reset while the request sits in CHECK aborts it.
        @(negedge clk);
        req_user = 4'd1; req_fluid = 2'd0; req_vol = 8'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            if (resp_valid) cnt++;
            @(negedge clk);
        end
        chk("s6.no_resp", 32'(cnt), 0);
        chk_reset("s6");
        do_req("s6.u1", tbl[0]);
        v = '{4'd2, 2'd0, 8'd1, 8'd0, ST_OK, 8'd1, 8'd0, 16'd10, 16'd10, 8'd48, 3'b000};
        do_req("s6.u2", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
